sequence_copier: RTL and testbench

- Downstream neighbour of the four-saver selector inside channel_monitor.
- Tracks which sequence savers hold a finished sequence and drains the one named by next_copy_from, word by word, onto a valid/ready output stream.
- Drives copy_job, which advances the selector's copy pointer, and A..D_copied, which release each saver back to RESET.

---
 rtl/sequence_copier.sv | 118 +++++++++++
 tb/tb_sequence_copier.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_copier.sv
// sequence_copier: drains finished sequences from four savers onto a valid/ready stream
//   entry_clock, reset           : clock, async active-high reset
//   next_copy_from[3:0]          : one-hot saver to copy next (D,C,B,A)
//   X_saved / X_data             : saver-finished pulses and saver read data (1-cycle latency)
//   rd_addr                      : read address broadcast to all savers
//   copy_job                     : one-hot saver being copied, 0 when idle
//   X_copied                     : one-cycle pulse when a saver's copy completes
//   out_data/valid/ready/last    : output word stream
//   overrun, sel_err             : sticky error flags
module sequence_copier #(
   parameter int DATA_W  = 16,
   parameter int SEQ_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              entry_clock,
   input  logic              reset,
   input  logic [3:0]        next_copy_from,
   input  logic              A_saved,
   input  logic              B_saved,
   input  logic              C_saved,
   input  logic              D_saved,
   input  logic [DATA_W-1:0] A_data,
   input  logic [DATA_W-1:0] B_data,
   input  logic [DATA_W-1:0] C_data,
   input  logic [DATA_W-1:0] D_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [3:0]        copy_job,
   output logic              A_copied,
   output logic              B_copied,
   output logic              C_copied,
   output logic              D_copied,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              overrun,
   output logic              sel_err
);
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(SEQ_LEN);
   localparam logic [ADDR_W:0] LAST = LEN - 1'b1;
   state_t              state_q;
   logic [3:0]          pending_q, job_q, copied_q;
   logic [ADDR_W:0]     rd_cnt_q, acc_cnt_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                inflight_q, overrun_q, sel_err_q;
   logic [1:0]          cnt_q, cnt_d, wr_idx;
   logic [DATA_W-1:0]   buf0_q, buf1_q, buf0_d, buf1_d, rd_data;
   logic [3:0]          saved;
   logic                one_hot, accept, issue, done_go;
   assign saved    = {D_saved, C_saved, B_saved, A_saved};
   assign one_hot  = (next_copy_from != 4'd0) && ((next_copy_from & (next_copy_from - 4'd1)) == 4'd0);
   assign accept   = out_valid && out_ready;
   // occupancy after this cycle's accept plus the word already in flight
   assign wr_idx   = cnt_q - {1'b0, accept};
   assign cnt_d    = wr_idx + {1'b0, inflight_q};
   assign issue    = (state_q == STREAM) && (rd_cnt_q < LEN) && (cnt_d < 2'd2);
   assign done_go  = (state_q == STREAM) && accept && (acc_cnt_q == LAST);
   assign rd_data  = ({DATA_W{job_q[0]}} & A_data) | ({DATA_W{job_q[1]}} & B_data) |
                     ({DATA_W{job_q[2]}} & C_data) | ({DATA_W{job_q[3]}} & D_data);
   // two-entry buffer with head at entry 0; returning word lands behind whatever remains
   assign buf0_d   = (inflight_q && wr_idx == 2'd0) ? rd_data : accept ? buf1_q : buf0_q;
   assign buf1_d   = (inflight_q && wr_idx == 2'd1) ? rd_data : buf1_q;
   assign rd_addr  = issue ? rd_cnt_q[ADDR_W-1:0] : rd_addr_q;
   assign copy_job = job_q;
   assign {D_copied, C_copied, B_copied, A_copied} = copied_q;
   assign out_data  = buf0_q;
   assign out_valid = cnt_q != 2'd0;
   assign out_last  = out_valid && (acc_cnt_q == LAST);
   assign overrun   = overrun_q;
   assign sel_err   = sel_err_q;
   always_ff @(posedge entry_clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         job_q      <= '0;
         copied_q   <= '0;
         rd_cnt_q   <= '0;
         acc_cnt_q  <= '0;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
         overrun_q  <= 1'b0;
         sel_err_q  <= 1'b0;
         cnt_q      <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         // a new save in the DONE cycle outlives the clear
         pending_q  <= (pending_q & ~((state_q == DONE) ? job_q : 4'd0)) | saved;
         overrun_q  <= overrun_q | (|(saved & pending_q));
         copied_q   <= done_go ? job_q : 4'd0;
         cnt_q      <= cnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         inflight_q <= issue;
         if (issue) begin
            rd_addr_q <= rd_cnt_q[ADDR_W-1:0];
            rd_cnt_q  <= rd_cnt_q + 1'b1;
         end
         if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (one_hot && |(next_copy_from & pending_q)) begin
                  job_q     <= next_copy_from;
                  rd_cnt_q  <= '0;
                  acc_cnt_q <= '0;
                  state_q   <= STREAM;
               end else if (|pending_q && !one_hot) sel_err_q <= 1'b1;
            end
            STREAM: if (done_go) state_q <= DONE;
            default: begin
               job_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sequence_copier.sv
// tb_sequence_copier: directed-plus-random bench for sequence_copier against a word-level reference model
module tb_sequence_copier;
   localparam int DW = 16, SL = 16, AW = 4;
   logic          clk = 1'b0, reset = 1'b1;
   logic [3:0]    nxt = 4'b0001, saved = 4'b0000, copied, copy_job;
   logic [DW-1:0] dat [4];
   logic [DW-1:0] base [4];
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready = 1'b0, out_last, overrun, sel_err;
   logic [3:0]    mpend = 4'b0000;
   logic          exp_ovr = 1'b0, exp_sel = 1'b0;
   int            checks = 0, errors = 0, fv = 0;

   sequence_copier #(.DATA_W(DW), .SEQ_LEN(SL), .ADDR_W(AW)) dut (
      .entry_clock(clk), .reset(reset), .next_copy_from(nxt),
      .A_saved(saved[0]), .B_saved(saved[1]), .C_saved(saved[2]), .D_saved(saved[3]),
      .A_data(dat[0]), .B_data(dat[1]), .C_data(dat[2]), .D_data(dat[3]),
      .rd_addr(rd_addr), .copy_job(copy_job),
      .A_copied(copied[0]), .B_copied(copied[1]), .C_copied(copied[2]), .D_copied(copied[3]),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .overrun(overrun), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   // saver memories: word at address a is base + a, returned one cycle after the address
   always_ff @(posedge clk) for (int i = 0; i < 4; i++) dat[i] <= base[i] + DW'(rd_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] mask);
      exp_ovr = exp_ovr | (|(mask & mpend));
      mpend   = mpend | mask;
      saved   = mask;
      step();
      saved   = 4'b0000;
   endtask

   task automatic status_check(input string tag);
      @(negedge clk);
      chk({tag, "_overrun"}, overrun, exp_ovr);
      chk({tag, "_sel_err"}, sel_err, exp_sel);
      step();
   endtask

   // follows one whole copy of saver s; mode 0 ready high, 1 pattern 1001, 2 random
   task automatic copy_check(input int s, input int mode, input logic [3:0] nxt_after,
                             input bit resave, output int first_v);
      logic [3:0]    oh;
      logic [DW-1:0] hd;
      int            idx, cyc, pat;
      bit            held;
      oh = 4'(1 << s);
      idx = 0; cyc = 0; pat = 0; held = 0; hd = '0; first_v = -1;
      while (idx < SL && cyc < 400) begin
         out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'($urandom_range(0, 1));
         pat++;
         @(negedge clk);
         chk("copy_job_legal", (copy_job === 4'd0) || (copy_job === oh), 1);
         chk("copied_early", copied, 0);
         if (copy_job === oh) nxt = nxt_after;
         if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, hd);
         end
         if (mode == 0 && first_v >= 0) chk("stream_gap", out_valid, 1);
         if (out_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            chk("data", out_data, DW'(base[s] + DW'(idx)));
            chk("last", out_last, idx == SL - 1);
            if (out_ready) begin
               idx++;
               held = 0;
            end else begin
               held = 1;
               hd = out_data;
            end
         end
         step();
         cyc++;
      end
      if (idx < SL) chk("copy_timeout", idx, SL);
      if (resave) begin
         exp_ovr = exp_ovr | mpend[s];
         saved = oh;
      end
      mpend[s] = resave;
      @(negedge clk);
      chk("copied_pulse", copied, oh);
      chk("job_in_done", copy_job, oh);
      chk("valid_in_done", out_valid, 0);
      step();
      saved = 4'b0000;
      @(negedge clk);
      chk("copied_clear", copied, 0);
      chk("job_idle", copy_job, 0);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [3:0] oh;
      for (int i = 0; i < 4; i++) base[i] = 16'($urandom);
      base[0] = 16'h0100;
      step();
      step();
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_job", copy_job, 0);
      chk("rst_copied", copied, 0);
      chk("rst_last", out_last, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_sel_err", sel_err, 0);
      chk("rst_rd_addr", rd_addr, 0);
      step();
      reset = 1'b0;
      step();
      // single copy of A, no backpressure
      nxt = 4'b0001;
      pulse(4'b0001);
      copy_check(0, 0, 4'b0001, 0, fv);
      chk("first_valid_latency", fv, 3);
      status_check("single");
      // backpressure on B
      nxt = 4'b0010;
      pulse(4'b0010);
      copy_check(1, 1, 4'b0010, 0, fv);
      status_check("backpressure");
      // round robin C then D, selector advanced once C's copy is seen
      nxt = 4'b0100;
      pulse(4'b1100);
      copy_check(2, 2, 4'b1000, 0, fv);
      copy_check(3, 0, 4'b1000, 0, fv);
      status_check("round_robin");
      // random copies
      for (int k = 0; k < 3; k++) begin
         s = $urandom_range(0, 3);
         oh = 4'(1 << s);
         base[s] = 16'($urandom);
         nxt = oh;
         pulse(oh);
         copy_check(s, 2, oh, 0, fv);
      end
      status_check("random");
      // double save of A before it is copied, then a save in A's DONE cycle
      nxt = 4'b0100;
      pulse(4'b0001);
      pulse(4'b0001);
      status_check("overrun");
      nxt = 4'b0001;
      copy_check(0, 0, 4'b0001, 1, fv);
      copy_check(0, 1, 4'b0001, 0, fv);
      status_check("resave");
      // non-one-hot selector while B is pending
      nxt = 4'b0011;
      pulse(4'b0010);
      exp_sel = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("bad_sel_err", sel_err, 1);
      chk("bad_sel_job", copy_job, 0);
      chk("bad_sel_valid", out_valid, 0);
      step();
      nxt = 4'b0010;
      copy_check(1, 2, 4'b0010, 0, fv);
      status_check("sel_recover");
      // reset in the middle of a stream
      nxt = 4'b0001;
      base[0] = 16'($urandom);
      pulse(4'b0001);
      begin
         int n = 0;
         out_ready = 1'b0;
         @(negedge clk);
         while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("midrst_reached_valid", out_valid, 1);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_job", copy_job, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_sel_err", sel_err, 0);
      step();
      chk("midrst_no_copied", copied, 0);
      reset = 1'b0;
      mpend = 4'b0000;
      exp_ovr = 1'b0;
      exp_sel = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("postrst_job", copy_job, 0);
         chk("postrst_copied", copied, 0);
         chk("postrst_valid", out_valid, 0);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
